// File: rtl/tiny_rv_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tiny_rv_wb_arbiter                                            |
// | Purpose  : Write-back arbiter for the dual-read register file. Merges    |
// |            ALU and LSU results onto the single register-file write port, |
// |            buffers LSU results in a small FIFO and keeps a per-register  |
// |            busy scoreboard that stalls issue until pending writes land.  |
// | Ports    : i_clk, i_rst         clock, synchronous active-high reset     |
// |            i_issue_*            instruction presented for issue          |
// |            o_hazard             presented instruction must not issue     |
// |            i_alu_*              ALU result (never back-pressured)        |
// |            i_lsu_*, o_lsu_ready LSU result handshake                     |
// |            o_wb_addr, o_wb_data registered register-file write port      |
// |            o_busy               scoreboard, bit n = write to xn pending  |
// |            o_err                sticky unexpected-result flag            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tiny_rv_wb_arbiter #(
  parameter int XLEN           = 32,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  input  logic [4:0]      i_issue_rs1,
  input  logic [4:0]      i_issue_rs2,
  output logic            o_hazard,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [4:0]      i_lsu_rd,
  input  logic [XLEN-1:0] i_lsu_data,
  output logic [4:0]      o_wb_addr,
  output logic [XLEN-1:0] o_wb_data,
  output logic [31:0]     o_busy,
  output logic            o_err
);

  localparam int PTR_W = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(LSU_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(LSU_FIFO_DEPTH);

  logic [31:0]      busy;
  logic [31:0]      busy_next;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;

  logic [4:0]       fifo_rd   [LSU_FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data [LSU_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             full;
  logic             empty;
  logic             issue_accept;
  logic             alu_sel;
  logic             lsu_push;
  logic             fifo_pop;
  logic             err_set;
  logic [4:0]       wb_addr_next;
  logic [XLEN-1:0]  wb_data_next;

  always_comb begin
    full         = (count == FULL_COUNT);
    empty        = (count == '0);
    o_hazard     = i_issue_valid & (busy[i_issue_rs1] | busy[i_issue_rs2] | busy[i_issue_rd]);
    issue_accept = i_issue_valid & ~o_hazard;
    // rd=0 results are discarded, so they are accepted even with the FIFO full.
    o_lsu_ready  = ~i_rst & (~full | (i_lsu_rd == 5'd0));
    lsu_push     = i_lsu_valid & o_lsu_ready & (i_lsu_rd != 5'd0);
    alu_sel      = i_alu_valid & (i_alu_rd != 5'd0);
    // No same-cycle bypass: a push this cycle is only visible to the pop next cycle.
    fifo_pop     = ~alu_sel & ~empty;

    set_mask     = issue_accept ? (32'd1 << i_issue_rd) : 32'd0;
    // The value currently on the write port lands in the register file at this edge.
    clr_mask     = 32'd1 << o_wb_addr;
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;

    err_set      = (alu_sel & ~busy[i_alu_rd]) | (lsu_push & ~busy[i_lsu_rd]);

    wb_addr_next = 5'd0;
    wb_data_next = '0;
    if (alu_sel) begin
      wb_addr_next = i_alu_rd;
      wb_data_next = i_alu_data;
    end else if (fifo_pop) begin
      wb_addr_next = fifo_rd[rd_ptr];
      wb_data_next = fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy      <= 32'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_wb_addr <= 5'd0;
      o_wb_data <= '0;
      o_err     <= 1'b0;
    end else begin
      busy      <= busy_next;
      o_wb_addr <= wb_addr_next;
      o_wb_data <= wb_data_next;
      if (err_set) begin
        o_err <= 1'b1;
      end
      if (lsu_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({lsu_push, fifo_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count register alone decides validity.
  always_ff @(posedge i_clk) begin
    if (lsu_push) begin
      fifo_rd[wr_ptr]   <= i_lsu_rd;
      fifo_data[wr_ptr] <= i_lsu_data;
    end
  end

  assign o_busy = busy;

endmodule
`default_nettype wire

// File: tb/tb_tiny_rv_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tiny_rv_wb_arbiter                                         |
// | Purpose  : Self-checking bench for tiny_rv_wb_arbiter with directed      |
// |            scenarios and randomized traffic against a queue-based model. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_tiny_rv_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_rd, issue_rs1, issue_rs2;
  logic            hazard;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     busy;
  logic            err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tiny_rv_wb_arbiter #(.XLEN(XLEN), .LSU_FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_issue_rs1(issue_rs1), .i_issue_rs2(issue_rs2), .o_hazard(hazard),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready),
    .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
    .o_wb_addr(wb_addr), .o_wb_data(wb_data), .o_busy(busy), .o_err(err)
  );

  // Reference model: pending-write set, FIFO as a queue, registered write port.
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            m_q[$];
  logic [31:0]     m_busy    = '0;
  logic [4:0]      m_wb_addr = '0;
  logic [XLEN-1:0] m_wb_data = '0;
  logic            m_err     = 1'b0;

  function automatic logic m_hazard();
    return issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]);
  endfunction

  function automatic logic m_ready();
    return !rst && ((m_q.size() < DEPTH) || (lsu_rd == 5'd0));
  endfunction

  // Advance one clock: capture the driven inputs, take the edge, update the model.
  task automatic step();
    logic s_rst, s_acc, s_rdy, s_av, s_lv;
    logic [4:0] s_ird, s_ard, s_lrd;
    logic [XLEN-1:0] s_ad, s_ld;
    logic [31:0] nb;
    #1;
    s_rst = rst; s_acc = issue_valid && !m_hazard(); s_rdy = m_ready();
    s_ird = issue_rd; s_av = alu_valid; s_ard = alu_rd; s_ad = alu_data;
    s_lv = lsu_valid; s_lrd = lsu_rd; s_ld = lsu_data;
    @(posedge clk);
    if (s_rst) begin
      m_q.delete(); m_busy = '0; m_wb_addr = '0; m_wb_data = '0; m_err = 1'b0;
    end else begin
      nb = m_busy;
      if (m_wb_addr != 0) nb[m_wb_addr] = 1'b0;
      if (s_acc && s_ird != 0) nb[s_ird] = 1'b1;
      if (s_av && s_ard != 0 && !m_busy[s_ard]) m_err = 1'b1;
      if (s_lv && s_rdy && s_lrd != 0 && !m_busy[s_lrd]) m_err = 1'b1;
      if (s_av && s_ard != 0) begin
        m_wb_addr = s_ard; m_wb_data = s_ad;
      end else if (m_q.size() > 0) begin
        m_wb_addr = m_q[0].rd; m_wb_data = m_q[0].data; void'(m_q.pop_front());
      end else begin
        m_wb_addr = '0; m_wb_data = '0;
      end
      if (s_lv && s_rdy && s_lrd != 0) m_q.push_back('{rd: s_lrd, data: s_ld});
      m_busy = nb;
    end
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_rd = rd; issue_rs1 = 0; issue_rs2 = 0;
    step();
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    checks++;
    if (lsu_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low: got %b want 0", lsu_ready); end
    step(); step();
    checks++;
    if ({wb_addr, wb_data, busy, err} !== {5'd0, 32'd0, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got addr=%0d data=%h busy=%h err=%b want all 0", wb_addr, wb_data, busy, err);
    end
    rst = 0;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_release: got %b want 1", lsu_ready); end
  endtask

  task automatic test_issue_alu();
    do_reset();
    issue_valid = 1; issue_rd = 5;
    #1;
    checks++;
    if (hazard !== 1'b0) begin failures++; $display("FAIL issue_nohazard: got %b want 0", hazard); end
    step();
    issue_valid = 0; issue_rd = 0;
    checks++;
    if (busy !== 32'h20) begin failures++; $display("FAIL issue_busy_set: got %h want 00000020", busy); end
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    checks++;
    if ({wb_addr, wb_data, busy} !== {5'd5, 32'hDEADBEEF, 32'h20}) begin
      failures++;
      $display("FAIL alu_write: got addr=%0d data=%h busy=%h want 5 deadbeef 00000020", wb_addr, wb_data, busy);
    end
    step();
    checks++;
    if ({wb_addr, busy, err} !== {5'd0, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL alu_busy_clear: got addr=%0d busy=%h err=%b want 0 0 0", wb_addr, busy, err);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    issue(7);
    issue_valid = 1; issue_rs1 = 7; issue_rs2 = 0; issue_rd = 1;
    #1;
    checks++;
    if (hazard !== 1'b1) begin failures++; $display("FAIL hazard_rs1: got %b want 1", hazard); end
    step();
    checks++;
    if (busy !== 32'h80) begin failures++; $display("FAIL hazard_no_set: got %h want 00000080", busy); end
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    #1;
    checks++;
    if (hazard !== 1'b0) begin failures++; $display("FAIL hazard_x0: got %b want 0", hazard); end
    step();
    idle_inputs();
    checks++;
    if (busy !== 32'h80) begin failures++; $display("FAIL hazard_x0_busy: got %h want 00000080", busy); end
  endtask

  task automatic test_fifo_full();
    logic [4:0] exp_addr [3];
    logic [XLEN-1:0] exp_data [3];
    exp_addr = '{5'd4, 5'd6, 5'd0};
    exp_data = '{32'h44, 32'h66, 32'h0};
    do_reset();
    issue(3); issue(4); issue(6);
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 3; alu_data = 32'h30 + i;
      lsu_valid = 1;
      lsu_rd    = (i == 0) ? 5'd4 : (i == 1) ? 5'd6 : 5'd8;
      lsu_data  = (i == 0) ? 32'h44 : (i == 1) ? 32'h66 : 32'h88;
      #1;
      checks++;
      if (lsu_ready !== (i < 2)) begin
        failures++; $display("FAIL full_ready cycle %0d: got %b want %b", i, lsu_ready, (i < 2));
      end
      step();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({wb_addr, wb_data} !== {exp_addr[i], exp_data[i]}) begin
        failures++;
        $display("FAIL drain_%0d: got addr=%0d data=%h want %0d %h", i, wb_addr, wb_data, exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h5678;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin failures++; $display("FAIL rd0_ready: got %b want 1", lsu_ready); end
    step();
    idle_inputs();
    checks++;
    if ({wb_addr, err} !== {5'd0, 1'b0}) begin
      failures++; $display("FAIL rd0_no_write: got addr=%0d err=%b want 0 0", wb_addr, err);
    end
    // Fill the FIFO behind ALU writes, then offer an rd=0 LSU result while full.
    issue(10); issue(11); issue(12); issue(13);
    alu_valid = 1; alu_rd = 12; lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hA0; step();
    alu_rd = 13; lsu_rd = 11; lsu_data = 32'hB0; step();
    alu_valid = 0; alu_rd = 0; lsu_rd = 0; lsu_data = 32'hFF;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin failures++; $display("FAIL rd0_full_ready: got %b want 1", lsu_ready); end
    step();
    idle_inputs();
    checks++;
    if (wb_addr !== 5'd10) begin failures++; $display("FAIL rd0_full_pop: got %0d want 10", wb_addr); end
    step(); step();
    checks++;
    if ({wb_addr, busy, err} !== {5'd0, 32'd0, 1'b0}) begin
      failures++; $display("FAIL rd0_end: got addr=%0d busy=%h err=%b want 0 0 0", wb_addr, busy, err);
    end
  endtask

  task automatic test_err();
    do_reset();
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    step();
    idle_inputs();
    checks++;
    if ({err, wb_addr, wb_data} !== {1'b1, 5'd9, 32'h99}) begin
      failures++; $display("FAIL err_set: got err=%b addr=%0d data=%h want 1 9 99", err, wb_addr, wb_data);
    end
    step(); step(); step();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_flush();
    issue(4); issue(5); issue(6); issue(7);
    alu_valid = 1; alu_rd = 6; lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h55; step();
    alu_rd = 4; alu_data = 32'h40; lsu_rd = 7; lsu_data = 32'h77; step();
    idle_inputs();
    checks++;
    if ({wb_addr, busy} !== {5'd4, 32'hB0}) begin
      failures++; $display("FAIL flush_pre: got addr=%0d busy=%h want 4 000000b0", wb_addr, busy);
    end
    rst = 1;
    #1;
    checks++;
    if (lsu_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", lsu_ready); end
    step();
    rst = 0;
    checks++;
    if ({wb_addr, busy, err} !== {5'd0, 32'd0, 1'b0}) begin
      failures++; $display("FAIL flush_reset: got addr=%0d busy=%h err=%b want 0 0 0", wb_addr, busy, err);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (wb_addr !== 5'd0) begin failures++; $display("FAIL flush_nowrite_%0d: got %0d want 0", i, wb_addr); end
    end
  endtask

  function automatic logic [4:0] pick_rd();
    logic [4:0] cand[$];
    for (int r = 1; r < 8; r++) if (m_busy[r]) cand.push_back(5'(r));
    if (cand.size() > 0 && $urandom_range(0, 4) != 0) return cand[$urandom_range(0, cand.size() - 1)];
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom_range(0, 7));
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      alu_valid   = ($urandom_range(0, 9) < 4);
      alu_rd      = pick_rd();
      alu_data    = $urandom;
      lsu_valid   = $urandom_range(0, 1);
      lsu_rd      = pick_rd();
      lsu_data    = $urandom;
      #1;
      checks++;
      if ({hazard, lsu_ready} !== {m_hazard(), m_ready()}) begin
        failures++;
        $display("FAIL rand_comb cyc %0d: got hazard=%b ready=%b want %b %b", i, hazard, lsu_ready, m_hazard(), m_ready());
      end
      step();
      checks++;
      if ({wb_addr, wb_data, busy, err} !== {m_wb_addr, m_wb_data, m_busy, m_err}) begin
        failures++;
        $display("FAIL rand_state cyc %0d: got addr=%0d data=%h busy=%h err=%b want %0d %h %h %b",
                 i, wb_addr, wb_data, busy, err, m_wb_addr, m_wb_data, m_busy, m_err);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_issue_alu();
    test_hazard();
    test_fifo_full();
    test_rd_zero();
    test_err();
    test_reset_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
